// File: rtl/par_ser_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial converter.
package par_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  function automatic int beats(input int par_sz, input int word_sz);
    return par_sz / word_sz;
  endfunction

  // Counter must be able to hold BEATS, hence the +1.
  function automatic int cnt_width(input int n_beats);
    return (n_beats < 1) ? 1 : $clog2(n_beats + 1);
  endfunction

endpackage

// File: rtl/par_serializer_if.sv
// Handshake and serial-beat bundle between producer, serializer and line side.
interface par_serializer_if #(
  parameter int PAR_SZ  = 8,
  parameter int WORD_SZ = 1
);
  logic [PAR_SZ-1:0]  par;
  logic               par_valid;
  logic               ready;
  logic               tick;
  logic [WORD_SZ-1:0] seq;
  logic               seq_valid;
  logic               seq_last;

  modport master (
    output par, par_valid, tick,
    input  ready, seq, seq_valid, seq_last
  );

  modport slave (
    input  par, par_valid, tick,
    output ready, seq, seq_valid, seq_last
  );
endinterface

// File: rtl/par_ser_shreg.sv
// Loadable shift register stepping WORD_SZ bits per shift; exposes the beat that
// will sit at the output end after this cycle's load/shift.
module par_ser_shreg #(
  parameter int PAR_SZ    = 8,
  parameter int WORD_SZ   = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [PAR_SZ-1:0]  din,
  output logic [WORD_SZ-1:0] head_d
);

  logic [PAR_SZ-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = MSB_FIRST ? (sr_q << WORD_SZ) : (sr_q >> WORD_SZ);
    end
  end

  // Looking at the next contents lets the top register seq in the same cycle.
  always_comb begin
    head_d = MSB_FIRST ? sr_d[PAR_SZ-1 -: WORD_SZ] : sr_d[WORD_SZ-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial converter with tick pacing and back-to-back framing.
// Optional trailing parity beat is built when SER_PARITY_EN is defined.
module par_serializer
  import par_ser_pkg::*;
#(
  parameter int                 PAR_SZ    = 8,
  parameter int                 WORD_SZ   = 1,
  parameter bit                 MSB_FIRST = 1'b0,
  parameter logic [WORD_SZ-1:0] IDLE_VAL  = '0,
  parameter int                 ODD_PAR   = 0
) (
  input logic             clk,
  input logic             reset,
  par_serializer_if.slave bus
);

  localparam int             BEATS    = beats(PAR_SZ, WORD_SZ);
  localparam int             CW       = cnt_width(BEATS);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);
`ifdef SER_PARITY_EN
  localparam bit             PAR_EN   = 1'b1;
`else
  localparam bit             PAR_EN   = 1'b0;
`endif

  if ((PAR_SZ % WORD_SZ) != 0 || WORD_SZ > PAR_SZ) begin : g_bad_width
    $error("par_serializer: PAR_SZ must be a non-zero multiple of WORD_SZ");
  end
  if (ODD_PAR != 0 && ODD_PAR != 1) begin : g_bad_odd
    $error("par_serializer: ODD_PAR must be 0 or 1");
  end

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WORD_SZ-1:0] seq_q, seq_d;
  logic               seq_valid_q, seq_valid_d;
  logic               seq_last_q, seq_last_d;
  logic               last_beat, frame_end, ready, load, shift;
  logic [WORD_SZ-1:0] head_d;

  // The final beat is the parity beat when it exists, else the last data beat.
`ifdef SER_PARITY_EN
  logic par_bit_q, par_bit_d;
  assign last_beat = (state_q == PARITY);
`else
  assign last_beat = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif

  assign frame_end = last_beat && bus.tick;
  assign ready     = (state_q == IDLE) || frame_end;
  assign load      = bus.par_valid && ready;
  assign shift     = (state_q == SHIFT) && bus.tick && (cnt_q != LAST_CNT);

  par_ser_shreg #(
    .PAR_SZ    (PAR_SZ),
    .WORD_SZ   (WORD_SZ),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .din    (bus.par),
    .head_d (head_d)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    seq_valid_d = seq_valid_q;
    seq_last_d  = seq_last_q;
    if (load) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      seq_d       = head_d;
      seq_valid_d = 1'b1;
      seq_last_d  = (BEATS == 1) && !PAR_EN;
    end else if (frame_end) begin
      state_d     = IDLE;
      cnt_d       = '0;
      seq_d       = IDLE_VAL;
      seq_valid_d = 1'b0;
      seq_last_d  = 1'b0;
    end else if (shift) begin
      cnt_d      = cnt_q + 1'b1;
      seq_d      = head_d;
      seq_last_d = !PAR_EN && ((cnt_q + 1'b1) == LAST_CNT);
    end
`ifdef SER_PARITY_EN
    else if (state_q == SHIFT && bus.tick) begin
      state_d    = PARITY;
      seq_d      = WORD_SZ'(par_bit_q);
      seq_last_d = 1'b1;
    end
`endif
  end

`ifdef SER_PARITY_EN
  // Parity is taken from the word as captured, so later par changes cannot leak in.
  assign par_bit_d = load ? ((^bus.par) ^ (ODD_PAR != 0)) : par_bit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit_q <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seq_q       <= IDLE_VAL;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      seq_last_q  <= seq_last_d;
    end
  end

  assign bus.ready     = ready;
  assign bus.seq       = seq_q;
  assign bus.seq_valid = seq_valid_q;
  assign bus.seq_last  = seq_last_q;

endmodule

// File: tb/tb_par_serializer.sv
// Bench for par_serializer: two configurations (8x1 LSB-first, 8x2 MSB-first)
// checked cycle by cycle against a queue-of-beats reference model.
module tb_par_serializer;

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef int iq_t[$];

  typedef struct {
    logic [7:0]      word;
    int              tdiv;
    logic [3:0][1:0] exp;  // exp[k] = beat k
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  par_serializer_if #(.PAR_SZ(8), .WORD_SZ(1)) if0 ();
  par_serializer_if #(.PAR_SZ(8), .WORD_SZ(2)) if1 ();

  par_serializer #(
    .PAR_SZ(8), .WORD_SZ(1), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0), .ODD_PAR(0)
  ) dut0 (.clk(clk), .reset(reset), .bus(if0));

  par_serializer #(
    .PAR_SZ(8), .WORD_SZ(2), .MSB_FIRST(1'b1), .IDLE_VAL(2'b10), .ODD_PAR(1)
  ) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the queue holds the beats of the current frame still to be shown.
  iq_t mq0, mq1;
  int  nload0 = 0, nload1 = 0;
  bit  ld0, ld1;

  function automatic iq_t frame(input logic [7:0] w, input int ws, input bit msb, input int odd);
    iq_t q;
    for (int i = 0; i < 8 / ws; i++) begin
      int sh;
      sh = msb ? 8 - (i + 1) * ws : i * ws;
      q.push_back(int'((w >> sh) & ((8'd1 << ws) - 8'd1)));
    end
    if (PAR_EN) q.push_back(int'(^w) ^ odd);
    return q;
  endfunction

  function automatic bit mready(input int sz, input logic t);
    return (sz == 0) || (sz == 1 && t === 1'b1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq0 = {};
      mq1 = {};
    end else begin
      ld0 = (if0.par_valid === 1'b1) && mready(mq0.size(), if0.tick);
      ld1 = (if1.par_valid === 1'b1) && mready(mq1.size(), if1.tick);
      if (mq0.size() > 0 && if0.tick === 1'b1) void'(mq0.pop_front());
      if (mq1.size() > 0 && if1.tick === 1'b1) void'(mq1.pop_front());
      if (ld0) begin mq0 = frame(if0.par, 1, 1'b0, 0); nload0++; end
      if (ld1) begin mq1 = frame(if1.par, 2, 1'b1, 1); nload1++; end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("seq0",   if0.seq,       (mq0.size() != 0) ? mq0[0] : 0);
      check("valid0", if0.seq_valid, mq0.size() != 0);
      check("last0",  if0.seq_last,  mq0.size() == 1);
      check("ready0", if0.ready,     mready(mq0.size(), if0.tick));
      check("seq1",   if1.seq,       (mq1.size() != 0) ? mq1[0] : 2);
      check("valid1", if1.seq_valid, mq1.size() != 0);
      check("last1",  if1.seq_last,  mq1.size() == 1);
      check("ready1", if1.ready,     mready(mq1.size(), if1.tick));
    end
  end

  // Tick pacing: tdiv>0 ticks every tdiv-th cycle, tdiv<=0 ticks randomly.
  int tdiv0 = 1, tdiv1 = 1, cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if0.tick = (tdiv0 <= 0) ? 1'($urandom % 2) : ((cyc % tdiv0) == 0);
    if1.tick = (tdiv1 <= 0) ? 1'($urandom % 2) : ((cyc % tdiv1) == 0);
  end

  task automatic send0(input logic [7:0] w);
    int n;
    n = nload0;
    if0.par = w;
    if0.par_valid = 1'b1;
    for (int c = 0; c < 300 && nload0 == n; c++) begin
      @(posedge clk); #1;
    end
    if (nload0 == n) check("send0_accept_timeout", 0, 1);
    if0.par_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] w);
    int n;
    n = nload1;
    if1.par = w;
    if1.par_valid = 1'b1;
    for (int c = 0; c < 300 && nload1 == n; c++) begin
      @(posedge clk); #1;
    end
    if (nload1 == n) check("send1_accept_timeout", 0, 1);
    if1.par_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (mq0.size() == 0 && mq1.size() == 0) break;
      @(posedge clk); #1;
    end
    check("idle_timeout", (mq0.size() != 0) || (mq1.size() != 0), 0);
  endtask

  // Runs one frame on dut1, records beats 0..3 and checks each later beat is held tdiv cycles.
  task automatic run1(input logic [7:0] w, input int tdiv,
                      output logic [3:0][1:0] got, output bit hold_ok);
    int k, held;
    k = 0; held = 0; hold_ok = 1'b1; got = '0;
    tdiv1 = tdiv;
    send1(w);
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      if (if1.seq_valid === 1'b1) begin
        held++;
        if (if1.tick === 1'b1) begin
          got[k] = if1.seq;
          if (k > 0 && held != tdiv) hold_ok = 1'b0;
          k++;
          held = 0;
        end
      end
    end
    if (k < 4) check("run1_timeout", k, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            tbl[4];
    int              t1_exp[8];
    logic [3:0][1:0] got;
    bit              hold_ok;
    int              nv, nrdy;

    tbl[0] = '{word: 8'hC6, tdiv: 3, exp: {2'd2, 2'd1, 2'd0, 2'd3}};
    tbl[1] = '{word: 8'hA5, tdiv: 1, exp: {2'd1, 2'd1, 2'd2, 2'd2}};
    tbl[2] = '{word: 8'h0F, tdiv: 2, exp: {2'd3, 2'd3, 2'd0, 2'd0}};
    tbl[3] = '{word: 8'h3C, tdiv: 3, exp: {2'd0, 2'd3, 2'd3, 2'd0}};
    t1_exp = '{1, 0, 1, 0, 0, 1, 0, 1};

    reset = 1'b1;
    if0.par = '0; if0.par_valid = 1'b0;
    if1.par = '0; if1.par_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seq0",   if0.seq, 0);
    check("rst_valid0", if0.seq_valid, 0);
    check("rst_last0",  if0.seq_last, 0);
    check("rst_ready0", if0.ready, 1);
    check("rst_seq1",   if1.seq, 2'b10);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // LSB-first single-bit frame with a tick every cycle.
    tdiv0 = 1;
    send0(8'hA5);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_beat", if0.seq, t1_exp[k]);
      check("t1_last", if0.seq_last, (k == 7) && !PAR_EN);
    end
    if (PAR_EN) @(negedge clk);
    @(negedge clk);
    check("t1_idle_valid", if0.seq_valid, 0);
    check("t1_idle_seq",   if0.seq, 0);
    @(posedge clk); #1;

    // Table of 2-bit MSB-first frames at several tick rates.
    foreach (tbl[i]) begin
      run1(tbl[i].word, tbl[i].tdiv, got, hold_ok);
      for (int k = 0; k < 4; k++) check($sformatf("tbl%0d_beat%0d", i, k), got[k], tbl[i].exp[k]);
      check($sformatf("tbl%0d_hold", i), hold_ok, 1);
      wait_idle();
    end

    // Back-to-back words with par_valid held: one ready pulse per frame end, no gap.
    tdiv0 = 1;
    nv = 0; nrdy = 0;
    send0(8'h0F);
    if0.par = 8'hF0;
    if0.par_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if0.seq_valid === 1'b1) nv++;
      if (if0.seq_valid === 1'b1 && if0.ready === 1'b1) nrdy++;
      if (if0.seq_valid !== 1'b1) break;
      if (if0.ready === 1'b1) begin
        @(posedge clk); #1;
        if0.par_valid = 1'b0;
      end
    end
    if0.par_valid = 1'b0;
    check("b2b_valid_beats", nv, PAR_EN ? 18 : 16);
    check("b2b_ready_pulses", nrdy, 2);
    wait_idle();

    // Reset in the middle of a frame clears outputs without a clock edge.
    send0(8'hFF);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_seq0",   if0.seq, 0);
    check("mid_rst_valid0", if0.seq_valid, 0);
    check("mid_rst_ready0", if0.ready, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send0(8'h80);
    @(negedge clk);
    check("post_rst_beat0", if0.seq, 0);
    check("post_rst_valid", if0.seq_valid, 1);
    wait_idle();

    // Random words, gaps and tick patterns on both instances against the model.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          tdiv0 = $urandom_range(0, 3);
          send0(8'($urandom));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          tdiv1 = $urandom_range(0, 3);
          send1(8'($urandom));
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    tdiv0 = 1; tdiv1 = 1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
